univ_shift_ctrl: RTL and testbench

Command sequencer for the DW-bit universal shift register (`ctrl` 00 load, 01 shift toward bit 0, 10 shift toward bit DW-1, 11 hold). Accepts one command at a time over a valid/ready handshake and drives the register's `ctrl`/`data`/`data_l`/`data_h` for the number of cycles the command requires. It also streams out the bit that leaves the register on every shift and pulses `done` on completion. It sits between the register and whatever block issues load/shift/rotate operations.

---
 rtl/univ_shift_ctrl.sv | 140 ++++++++++++++
 tb/tb_univ_shift_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_ctrl.sv
// Command sequencer for a DW-bit universal shift register: accepts load/shift/rotate
// commands over valid/ready and drives the register's control and serial inputs.
module univ_shift_ctrl #(
   parameter int DW = 4,
   parameter int NW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [DW-1:0] cmd_data,
   input  logic [NW-1:0] cmd_cnt,
   input  logic          cmd_fill,
   input  logic          cmd_rot,
   input  logic [DW-1:0] sr_q,
   output logic [1:0]    sr_ctrl,
   output logic [DW-1:0] sr_data,
   output logic          sr_data_l,
   output logic          sr_data_h,
   output logic          shout_valid,
   output logic          shout_bit,
   output logic          busy,
   output logic          done
);

   // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
   // are both high; cmd_ready is high only in IDLE, inputs are ignored otherwise.

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SHR  = 2'b01;
   localparam logic [1:0] OP_SHL  = 2'b10;
   localparam logic [1:0] CTRL_HOLD = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [1:0]    op_q;
   logic [DW-1:0] data_q;
   logic [NW-1:0] cnt_q, cnt_n;
   logic          fill_q, rot_q;
   logic          done_n;
   logic          accept;

   assign accept = cmd_valid && (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt_q  <= '0;
         done   <= 1'b0;
         op_q   <= '0;
         data_q <= '0;
         fill_q <= 1'b0;
         rot_q  <= 1'b0;
      end else begin
         state <= state_n;
         cnt_q <= cnt_n;
         done  <= done_n;
         if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            fill_q <= cmd_fill;
            rot_q  <= cmd_rot;
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt_q;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_LOAD: state_n = LOAD;
                  OP_SHR, OP_SHL: begin
                     // A zero count completes immediately, like NOP.
                     if (cmd_cnt != '0) begin
                        state_n = SHIFT;
                        cnt_n   = cmd_cnt;
                     end else begin
                        done_n = 1'b1;
                     end
                  end
                  default: done_n = 1'b1;
               endcase
            end
         end
         LOAD: begin
            state_n = IDLE;
            done_n  = 1'b1;
         end
         SHIFT: begin
            cnt_n = cnt_q - 1'b1;
            if (cnt_q == NW'(1)) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready   = (state == IDLE);
      busy        = (state != IDLE);
      sr_ctrl     = CTRL_HOLD;
      sr_data     = '0;
      sr_data_l   = 1'b0;
      sr_data_h   = 1'b0;
      shout_valid = 1'b0;
      shout_bit   = 1'b0;
      case (state)
         LOAD: begin
            sr_ctrl = OP_LOAD;
            sr_data = data_q;
         end
         SHIFT: begin
            shout_valid = 1'b1;
            if (op_q == OP_SHR) begin
               sr_ctrl   = OP_SHR;
               shout_bit = sr_q[0];
               sr_data_h = rot_q ? sr_q[0] : fill_q;
            end else begin
               sr_ctrl   = OP_SHL;
               shout_bit = sr_q[DW-1];
               sr_data_l = rot_q ? sr_q[DW-1] : fill_q;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_univ_shift_ctrl.sv
// Bench for univ_shift_ctrl: drives commands into the controller and a behavioural
// shift register, predicting every load, shift-out bit and done pulse from an arithmetic model.
module tb_univ_shift_ctrl;
   localparam int DW = 4;
   localparam int NW = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          cmd_valid, cmd_ready;
   logic [1:0]    cmd_op;
   logic [DW-1:0] cmd_data;
   logic [NW-1:0] cmd_cnt;
   logic          cmd_fill, cmd_rot;
   logic [DW-1:0] sr_q;
   logic [1:0]    sr_ctrl;
   logic [DW-1:0] sr_data;
   logic          sr_data_l, sr_data_h, shout_valid, shout_bit, busy, done;

   univ_shift_ctrl #(.DW(DW), .NW(NW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill), .cmd_rot(cmd_rot),
      .sr_q(sr_q), .sr_ctrl(sr_ctrl), .sr_data(sr_data),
      .sr_data_l(sr_data_l), .sr_data_h(sr_data_h),
      .shout_valid(shout_valid), .shout_bit(shout_bit), .busy(busy), .done(done)
   );

   // The controlled register itself (environment, not the checker model).
   logic [DW-1:0] sr_reg = '0;
   assign sr_q = sr_reg;
   always @(posedge clk) begin
      case (sr_ctrl)
         2'b00: sr_reg <= sr_data;
         2'b01: sr_reg <= {sr_data_h, sr_reg[DW-1:1]};
         2'b10: sr_reg <= {sr_reg[DW-2:0], sr_data_l};
         default: ;
      endcase
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int tests = 0;
   int fails = 0;
   int busy_until = 0;
   int done_count = 0;
   logic [DW-1:0] mdl = '0;
   logic [DW-1:0] load_q[$];
   logic [3:0]    shift_q[$];     // {ctrl, shifted-out bit, serial-in bit}
   logic [DW-1:0] done_val_q[$];
   int            done_cyc_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- driver ----------------
   task automatic issue(input logic [1:0] op, input logic [DW-1:0] data,
                        input logic [NW-1:0] cnt, input logic fill, input logic rot);
      int n = 0;
      int acc, lat, m, b_out, b_in;
      cmd_op = op; cmd_data = data; cmd_cnt = cnt; cmd_fill = fill; cmd_rot = rot;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         chk("accept_timeout", 32'd1, 32'd0);
      end else begin
         acc = cyc + 1;
         m = int'(mdl);
         lat = 0;
         if (op == 2'b00) begin
            load_q.push_back(data);
            m = int'(data);
            lat = 1;
         end else if (op != 2'b11) begin
            lat = int'(cnt);
            for (int i = 0; i < int'(cnt); i++) begin
               if (op == 2'b01) begin
                  b_out = m % 2;
                  b_in = rot ? b_out : int'(fill);
                  m = (m / 2) + b_in * (1 << (DW - 1));
               end else begin
                  b_out = m / (1 << (DW - 1));
                  b_in = rot ? b_out : int'(fill);
                  m = ((m * 2) + b_in) % (1 << DW);
               end
               shift_q.push_back({op, b_out[0], b_in[0]});
            end
         end
         mdl = m[DW-1:0];
         done_val_q.push_back(mdl);
         done_cyc_q.push_back(acc + lat);
         @(posedge clk);
         busy_until = acc + lat;
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      cmd_valid = 1'b0;
      @(negedge clk); #1;
      while ((done_cyc_q.size() != 0 || !cmd_ready) && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [3:0] e;
      chk("cmd_ready", cmd_ready, cyc >= busy_until);
      chk("busy", busy, cyc < busy_until);
      case (sr_ctrl)
         2'b11: begin
            chk("idle_shout_valid", shout_valid, 1'b0);
            chk("idle_sr_data", sr_data, '0);
         end
         2'b00: begin
            if (load_q.size() == 0) chk("unexpected_load", 32'd1, 32'd0);
            else chk("load_data", sr_data, load_q.pop_front());
         end
         default: begin
            if (shift_q.size() == 0) begin
               chk("unexpected_shift", 32'd1, 32'd0);
            end else begin
               e = shift_q.pop_front();
               chk("shift_ctrl", sr_ctrl, e[3:2]);
               chk("shout_valid", shout_valid, 1'b1);
               chk("shout_bit", shout_bit, e[1]);
               chk("serial_in", (sr_ctrl == 2'b01) ? sr_data_h : sr_data_l, e[0]);
            end
         end
      endcase
      if (done === 1'b1) begin
         done_count++;
         if (done_cyc_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            chk("done_cycle", cyc, done_cyc_q.pop_front());
            chk("done_value", sr_reg, done_val_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int d0;
      rst = 1'b1;
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'hF;
      cmd_cnt = '0; cmd_fill = 1'b0; cmd_rot = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_done", done, 1'b0);
      chk("rst_ctrl", sr_ctrl, 2'b11);
      chk("rst_data_l", sr_data_l, 1'b0);
      chk("rst_data_h", sr_data_h, 1'b0);
      chk("rst_shout_bit", shout_bit, 1'b0);
      chk("rst_reg_untouched", sr_reg, 4'h0);
      rst = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);

      issue(2'b00, 4'b1010, 3'd0, 1'b0, 1'b0);
      drain();
      chk("load_1010", sr_reg, 4'b1010);

      issue(2'b01, 4'h0, 3'd2, 1'b1, 1'b0);
      drain();
      chk("shr2_fill1", sr_reg, 4'b1110);

      issue(2'b00, 4'b1001, 3'd0, 1'b0, 1'b0);
      issue(2'b10, 4'h0, 3'd1, 1'b0, 1'b1);
      drain();
      chk("shl1_rot", sr_reg, 4'b0011);
      issue(2'b01, 4'h0, 3'd7, 1'b0, 1'b1);
      drain();
      chk("shr7_rot", sr_reg, 4'b0110);

      issue(2'b10, 4'h0, 3'd0, 1'b1, 1'b0);
      issue(2'b11, 4'h5, 3'd3, 1'b1, 1'b1);
      drain();
      chk("cnt0_nop_unchanged", sr_reg, 4'b0110);

      // Reset two shifts into a five-shift command.
      issue(2'b00, 4'b1111, 3'd0, 1'b0, 1'b0);
      issue(2'b01, 4'h0, 3'd5, 1'b0, 1'b0);
      cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      busy_until = cyc + 1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_reg", sr_reg, 4'b0011);
      chk("abort_ctrl", sr_ctrl, 2'b11);
      chk("abort_ready", cmd_ready, 1'b1);
      chk("abort_no_done", done, 1'b0);
      shift_q.delete();
      done_cyc_q.delete();
      done_val_q.delete();
      mdl = 4'b0011;
      repeat (3) @(negedge clk);

      d0 = done_count;
      issue(2'b00, 4'b0101, 3'd0, 1'b0, 1'b0);
      issue(2'b01, 4'h0, 3'd1, 1'b0, 1'b0);
      issue(2'b00, 4'b1100, 3'd0, 1'b0, 1'b0);
      drain();
      chk("b2b_done_pulses", done_count - d0, 3);
      chk("b2b_final", sr_reg, 4'b1100);

      for (int k = 0; k < 60; k++) begin
         issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      drain();
      chk("final_reg", sr_reg, mdl);
      chk("load_q_empty", load_q.size(), 0);
      chk("shift_q_empty", shift_q.size(), 0);
      chk("done_q_empty", done_cyc_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
